jtag_scan_sequencer: RTL and testbench

Autonomous JTAG master that drives the TAP controller's TMS/TDI pins and samples TDO, on behalf of a host or BIST engine. Each command optionally loads an instruction and then shifts a data register; for example, it selects the boundary-scan or internal-scan chain of the s9234 wrapper and exchanges a vector with it. It tracks a mirror of the IEEE 1149.1 TAP state, generates the exact TMS walk for each command, and returns the captured TDO bits. It sits between the test host and the TAP-level ports TMS, TDI and TDO.

---
 rtl/jtag_scan_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: walks the TAP through an optional IR scan and a DR scan per command,
// keeps a mirror of the 1149.1 TAP state and returns the TDO bits captured while shifting.
module jtag_scan_sequencer #(
    parameter int IR_W   = 2,
    parameter int DR_MAX = 64,
    parameter int LEN_W  = 7
) (
    input  logic              TCLK,
    input  logic              TRST,
    input  logic              start,
    input  logic              skip_ir,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [LEN_W-1:0]  dr_len,
    input  logic [DR_MAX-1:0] dr_in,
    input  logic              tdo,
    output logic              tms,
    output logic              tdi,
    output logic              busy,
    output logic              done,
    output logic [IR_W-1:0]   ir_out,
    output logic [DR_MAX-1:0] dr_out
);

    typedef enum logic [3:0] {
        WALK, SETTLE, IDLE, IR_HDR, IR_SH, IR_TL, DR_HDR, DR_SH, DR_TL, DONE
    } seq_e;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DR_MAX);
    localparam logic [LEN_W-1:0] IR_LAST = LEN_W'(IR_W - 1);

    seq_e              state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_c;
    logic [IR_W-1:0]   ir_sh_q, ir_mask_q;
    logic [DR_MAX-1:0] dr_sh_q, dr_mask_q;
    tap_e              tap_q, tap_d;
    logic              tms_d, busy_d, done_d;
    logic              accept;

    always_comb begin
        len_c  = (dr_len > LEN_MAX) ? LEN_MAX : dr_len;
        accept = (state_q == IDLE) && start;
    end

    // State register
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            state_q <= WALK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt counts cycles spent in the current state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            WALK:   if (cnt_q == LEN_W'(4)) state_d = SETTLE;
            SETTLE: state_d = IDLE;
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (!skip_ir)          state_d = IR_HDR;
                    else if (len_c != '0)  state_d = DR_HDR;
                    else                   state_d = DONE;
                end
            end
            IR_HDR: if (cnt_q == LEN_W'(3)) state_d = IR_SH;
            IR_SH:  if (cnt_q == IR_LAST)   state_d = IR_TL;
            IR_TL:  if (cnt_q == LEN_W'(1)) state_d = (len_q != '0) ? DR_HDR : DONE;
            DR_HDR: if (cnt_q == LEN_W'(2)) state_d = DR_SH;
            DR_SH:  if (cnt_q == len_q - 1'b1) state_d = DR_TL;
            DR_TL:  if (cnt_q == LEN_W'(1)) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = WALK;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the upcoming state so the registered pins line up with it
    always_comb begin
        tms_d = 1'b0;
        case (state_d)
            WALK:   tms_d = 1'b1;
            IR_HDR: tms_d = (cnt_d < LEN_W'(2));
            IR_SH:  tms_d = (cnt_d == IR_LAST);
            IR_TL:  tms_d = (cnt_d == '0);
            DR_HDR: tms_d = (cnt_d == '0);
            DR_SH:  tms_d = (cnt_d == len_q - 1'b1);
            DR_TL:  tms_d = (cnt_d == '0);
            default: tms_d = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            tms  <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
        end else begin
            tms  <= tms_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    // IEEE 1149.1 TAP transition table, driven by the pin value the TAP sees
    always_comb begin
        case (tap_q)
            TLR:     tap_d = tms ? TLR    : RTI;
            RTI:     tap_d = tms ? SEL_DR : RTI;
            SEL_DR:  tap_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_d = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_d = tms ? UPD_DR : PA_DR;
            PA_DR:   tap_d = tms ? EX2_DR : PA_DR;
            EX2_DR:  tap_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_d = tms ? SEL_DR : RTI;
            SEL_IR:  tap_d = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_d = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_d = tms ? UPD_IR : PA_IR;
            PA_IR:   tap_d = tms ? EX2_IR : PA_IR;
            EX2_IR:  tap_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_d = tms ? SEL_DR : RTI;
            default: tap_d = TLR;
        endcase
    end

    // Shift data out of consumed-bit shifters; captures land via a one-hot write mask
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            tap_q     <= TLR;
            len_q     <= '0;
            ir_sh_q   <= '0;
            dr_sh_q   <= '0;
            ir_mask_q <= '0;
            dr_mask_q <= '0;
            ir_out    <= '0;
            dr_out    <= '0;
            tdi       <= 1'b0;
        end else begin
            tap_q <= tap_d;

            if (accept) begin
                len_q     <= len_c;
                ir_sh_q   <= ir_in;
                dr_sh_q   <= dr_in;
                ir_mask_q <= IR_W'(1);
                dr_mask_q <= DR_MAX'(1);
                ir_out    <= '0;
                dr_out    <= '0;
            end else begin
                if (tap_q == SH_IR) begin
                    ir_out    <= ir_out | (ir_mask_q & {IR_W{tdo}});
                    ir_mask_q <= ir_mask_q << 1;
                end
                if (tap_q == SH_DR) begin
                    dr_out    <= dr_out | (dr_mask_q & {DR_MAX{tdo}});
                    dr_mask_q <= dr_mask_q << 1;
                end
            end

            if (state_d == IR_SH) begin
                tdi     <= ir_sh_q[0];
                ir_sh_q <= ir_sh_q >> 1;
            end else if (state_d == DR_SH) begin
                tdi     <= dr_sh_q[0];
                dr_sh_q <= dr_sh_q >> 1;
            end else begin
                tdi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: behavioural TAP with an IR and a loop-back DR chain,
// expected results queued per command and checked by a done-driven monitor.
module tb_jtag_scan_sequencer;

    localparam int IR_W   = 2;
    localparam int DR_MAX = 64;
    localparam int LEN_W  = 7;

    logic              TCLK    = 1'b0;
    logic              TRST    = 1'b1;
    logic              start   = 1'b0;
    logic              skip_ir = 1'b0;
    logic [IR_W-1:0]   ir_in   = '0;
    logic [LEN_W-1:0]  dr_len  = '0;
    logic [DR_MAX-1:0] dr_in   = '0;
    logic              tdo;
    logic              tms, tdi, busy, done;
    logic [IR_W-1:0]   ir_out;
    logic [DR_MAX-1:0] dr_out;

    jtag_scan_sequencer #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
        .TCLK(TCLK), .TRST(TRST), .start(start), .skip_ir(skip_ir),
        .ir_in(ir_in), .dr_len(dr_len), .dr_in(dr_in), .tdo(tdo),
        .tms(tms), .tdi(tdi), .busy(busy), .done(done),
        .ir_out(ir_out), .dr_out(dr_out)
    );

    always #5 TCLK = ~TCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge TCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural TAP ----------------
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    tap_t            mst    = T_TLR;
    logic [IR_W-1:0] m_irsh = '0;
    logic [IR_W-1:0] m_ir   = '0;
    logic [63:0]     chain  = '0;
    int              mdl_len = 8;
    logic            mdl_clr = 1'b0;

    always @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            mst <= T_TLR;
        end else begin
            mst <= tap_next(mst, tms);
            if (mst == T_CAPIR) m_irsh <= IR_W'(1);
            if (mst == T_SHIR)  m_irsh <= {tdi, m_irsh[IR_W-1:1]};
            if (mst == T_UPIR)  m_ir   <= m_irsh;
            if (mdl_clr)             chain <= '0;
            else if (mst == T_SHDR)  chain <= (chain >> 1) | ({63'd0, tdi} << (mdl_len - 1));
        end
    end

    assign tdo = (mst == T_SHIR) ? m_irsh[0] : (mst == T_SHDR) ? chain[0] : 1'b0;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DR_MAX-1:0] dr;
        int                lat;
        int                t0;
    } exp_t;

    exp_t q[$];

    always @(negedge TCLK) begin
        exp_t e;
        if (!TRST && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("ir_out", ir_out, e.ir);
                chk("dr_out", dr_out, e.dr);
                chk("latency", cyc - e.t0, e.lat);
                chk("busy_at_done", busy, 1);
                chk("tms_at_done", tms, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_vals();
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_ir_out", ir_out, 0);
        chk("rst_dr_out", dr_out, 0);
        chk("rst_tap", mst, T_TLR);
    endtask

    task automatic release_walk();
        TRST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("walk_tms", tms, (k < 5) ? 1 : 0);
            chk("walk_busy", busy, 1);
            @(negedge TCLK);
        end
        chk("walk_end_busy", busy, 0);
        chk("walk_end_tms", tms, 0);
        chk("walk_end_tap", mst, T_RTI);
    endtask

    task automatic run_cmd(input logic sk, input logic [IR_W-1:0] ir, input logic [LEN_W-1:0] ln,
                           input logic [DR_MAX-1:0] din, input logic [IR_W-1:0] e_ir,
                           input logic [DR_MAX-1:0] e_dr, input bit poke);
        logic [127:0] etms, etdi, rtms, rtdi;
        int en, n, len;
        bit got;
        exp_t e;
        etms = '0; etdi = '0; rtms = '0; rtdi = '0;
        en = 0; n = 0; got = 0;
        len = (int'(ln) > DR_MAX) ? DR_MAX : int'(ln);
        if (!sk) begin
            for (int i = 0; i < 4; i++) begin etms[en] = (i < 2); en++; end
            for (int i = 0; i < IR_W; i++) begin
                etms[en] = (i == IR_W - 1); etdi[en] = ir[i]; en++;
            end
            etms[en] = 1'b1; en++;
            etms[en] = 1'b0; en++;
        end
        if (len > 0) begin
            etms[en] = 1'b1; en++;
            etms[en] = 1'b0; en++;
            etms[en] = 1'b0; en++;
            for (int i = 0; i < len; i++) begin
                etms[en] = (i == len - 1); etdi[en] = din[i]; en++;
            end
            etms[en] = 1'b1; en++;
            etms[en] = 1'b0; en++;
        end
        e.ir = e_ir; e.dr = e_dr; e.lat = en + 1; e.t0 = cyc;
        q.push_back(e);
        skip_ir = sk; ir_in = ir; dr_len = ln; dr_in = din; start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge TCLK);
            if (k == 0) start = 1'b0;
            if (poke && k == 3) begin
                start = 1'b1; skip_ir = ~sk; ir_in = ~ir; dr_len = 7'd3; dr_in = ~din;
            end
            if (poke && k == 4) start = 1'b0;
            if (done) begin got = 1; break; end
            rtms[n] = tms; rtdi[n] = tdi; n++;
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("tms_len", n, en);
        chk("tms_stream", rtms, etms);
        chk("tdi_stream", rtdi, etdi);
        @(negedge TCLK);
    endtask

    task automatic run_abort(input logic [DR_MAX-1:0] din);
        skip_ir = 1'b1; ir_in = '0; dr_len = 7'd8; dr_in = din; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge TCLK);
            if (k == 0) start = 1'b0;
        end
        chk("abort_pre_tms", tms, 0);
        chk("abort_pre_busy", busy, 1);
        TRST = 1'b1;
        #1;
        check_reset_vals();
        @(negedge TCLK);
        release_walk();
    endtask

    task automatic clear_chain(input int ln);
        mdl_len = ln;
        mdl_clr = 1'b1;
        @(negedge TCLK);
        mdl_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge TCLK);
        check_reset_vals();
        release_walk();

        // IR load of 2'b10, no DR phase
        run_cmd(1'b0, 2'b10, 7'd0, '0, 2'b01, '0, 1'b0);
        chk("model_ir", m_ir, 2'b10);
        chk("tap_after_ir", mst, T_RTI);

        // 8-bit loop chain: first pass returns old contents, second returns A5
        clear_chain(8);
        run_cmd(1'b1, 2'b00, 7'd8, 64'hA5, 2'b00, 64'h0, 1'b0);
        run_cmd(1'b1, 2'b00, 7'd8, 64'hA5, 2'b00, 64'hA5, 1'b0);

        // Oversized length clamps to a 64-bit scan
        clear_chain(64);
        run_cmd(1'b1, 2'b00, 7'd100, '1, 2'b00, 64'h0, 1'b0);
        run_cmd(1'b1, 2'b00, 7'd100, '1, 2'b00, '1, 1'b0);

        // Empty command: immediate done, TAP untouched
        chk("tap_before_empty", mst, T_RTI);
        run_cmd(1'b1, 2'b11, 7'd0, '1, 2'b00, 64'h0, 1'b0);
        chk("tap_after_empty", mst, T_RTI);

        // Abort in the 3rd Shift-DR cycle: 3C shifted twice with ones becomes CF
        clear_chain(8);
        run_cmd(1'b1, 2'b00, 7'd8, 64'h3C, 2'b00, 64'h0, 1'b0);
        run_abort(64'hFF);
        run_cmd(1'b1, 2'b00, 7'd8, 64'h00, 2'b00, 64'hCF, 1'b1);

        repeat (3) @(negedge TCLK);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
